// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with a hardware zero-fill sequencer, a registered
// read port, a one-cycle request/valid handshake and a saturating write counter.
// After reset (and on a clear request) the sequencer walks every address
// writing zero; requests are ignored while it runs.
module ram_sp_clr #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int READ_MODE  = 0,   // 0 = read-first (old data), 1 = write-first (new data)
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    mem_we_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_s;
  logic [DATA_WIDTH-1:0]   rd_old_s;

  // Storage has no reset; the sequencer is responsible for zeroing it.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign rd_old_s = mem_q[addr];

  // Next-state, write-port and read-port decisions for the CLEAR/IDLE sequencer.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    cnt_d       = cnt_q;
    mem_we_s    = 1'b0;
    mem_addr_s  = addr;
    mem_wdata_s = wdata;
    case (state_q)
      ST_CLEAR: begin
        // Zero one word per cycle; a new clear request restarts the walk.
        mem_we_s    = 1'b1;
        mem_addr_s  = ptr_q;
        mem_wdata_s = '0;
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          // Clear wins over a simultaneous request; that request is dropped.
          state_d = ST_CLEAR;
          ptr_d   = '0;
          cnt_d   = '0;
        end else if (req) begin
          rvalid_d = 1'b1;
          if (we) begin
            mem_we_s = 1'b1;
            rdata_d  = (READ_MODE != 0) ? wdata : rd_old_s;
            if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            rdata_d = rd_old_s;
          end
        end else begin
          rvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Control and output registers with asynchronous active-high reset.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory write port; suppressed while reset is held.
  always_ff @(posedge clk_2) begin
    if (mem_we_s && !reset) begin
      mem_q[mem_addr_s] <= mem_wdata_s;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign busy     = (state_q == ST_CLEAR);
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Scoreboard bench for ram_sp_clr: two instances (read-first with 8-bit counter,
// write-first with 2-bit counter) share one stimulus stream. A behavioural model
// predicts each response and queues it; a negedge monitor pops and compares.
module tb_ram_sp_clr;

  localparam int DEPTH = 4;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       req;
  logic       we;
  logic [1:0] addr;
  logic [3:0] wdata;
  logic       clear;

  logic [3:0] rdata0, rdata1;
  logic       rvalid0, rvalid1;
  logic       busy0, busy1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  ram_sp_clr #(.ADDR_WIDTH(2), .DATA_WIDTH(4), .READ_MODE(0), .CNT_WIDTH(8)) dut0 (
    .clk_2(clk_2), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clear(clear), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .wr_count(cnt0)
  );

  ram_sp_clr #(.ADDR_WIDTH(2), .DATA_WIDTH(4), .READ_MODE(1), .CNT_WIDTH(2)) dut1 (
    .clk_2(clk_2), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clear(clear), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .wr_count(cnt1)
  );

  always #5 clk_2 = ~clk_2;

  // Reference model state
  logic [3:0] m_mem [DEPTH];
  int         m_busy_left;
  int         m_cnt0, m_cnt1;
  logic [3:0] q0 [$];
  logic [3:0] q1 [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 4'h0;
  endtask

  // Apply one cycle of stimulus; model the edge and queue expected responses.
  task automatic step(input logic r, input logic w, input logic [1:0] a,
                      input logic [3:0] d, input logic c);
    logic [3:0] old;
    req = r; we = w; addr = a; wdata = d; clear = c;
    @(posedge clk_2);
    if (m_busy_left > 0) begin
      if (c) m_busy_left = DEPTH;
      else   m_busy_left--;
    end else if (c) begin
      m_busy_left = DEPTH;
      m_cnt0 = 0;
      m_cnt1 = 0;
      model_zero();
    end else if (r) begin
      old = m_mem[a];
      if (w) begin
        m_mem[a] = d;
        q0.push_back(old);
        q1.push_back(d);
        if (m_cnt0 < 255) m_cnt0++;
        if (m_cnt1 < 3)   m_cnt1++;
      end else begin
        q0.push_back(old);
        q1.push_back(old);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
  endtask

  // Hold reset for three cycles, checking the reset values of both instances.
  task automatic do_reset();
    reset = 1'b1; req = 1'b0; we = 1'b0; clear = 1'b0; addr = 2'd0; wdata = 4'h0;
    q0.delete();
    q1.delete();
    m_busy_left = DEPTH;
    m_cnt0 = 0;
    m_cnt1 = 0;
    model_zero();
    #2;
    check("rst_busy0",   32'(busy0),   32'd1);
    check("rst_busy1",   32'(busy1),   32'd1);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rvalid1", 32'(rvalid1), 32'd0);
    check("rst_rdata0",  32'(rdata0),  32'd0);
    check("rst_rdata1",  32'(rdata1),  32'd0);
    check("rst_cnt0",    32'(cnt0),    32'd0);
    check("rst_cnt1",    32'(cnt1),    32'd0);
    repeat (3) @(posedge clk_2);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare status every cycle and pop the scoreboard on rvalid.
  always @(negedge clk_2) begin
    if (!reset) begin
      check("busy0", 32'(busy0), 32'(m_busy_left > 0));
      check("busy1", 32'(busy1), 32'(m_busy_left > 0));
      check("wr_count0", 32'(cnt0), m_cnt0);
      check("wr_count1", 32'(cnt1), m_cnt1);
      if (rvalid0) begin
        if (q0.size() == 0) check("rvalid0_unexpected", 32'(rvalid0), 32'd0);
        else                check("rdata0", 32'(rdata0), 32'(q0.pop_front()));
      end else if (q0.size() != 0) begin
        check("rvalid0_missing", 32'(rvalid0), 32'd1);
        void'(q0.pop_front());
      end
      if (rvalid1) begin
        if (q1.size() == 0) check("rvalid1_unexpected", 32'(rvalid1), 32'd0);
        else                check("rdata1", 32'(rdata1), 32'(q1.pop_front()));
      end else if (q1.size() != 0) begin
        check("rvalid1_missing", 32'(rvalid1), 32'd1);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    // Initial zero-fill window, then read every address.
    idle(5);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 2'(i), 4'h0, 1'b0);
    idle(1);

    // Writes followed by back-to-back reads.
    step(1'b1, 1'b1, 2'd1, 4'hA, 1'b0);
    step(1'b1, 1'b1, 2'd2, 4'h5, 1'b0);
    step(1'b1, 1'b1, 2'd3, 4'hF, 1'b0);
    step(1'b1, 1'b0, 2'd1, 4'h0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 4'h0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 4'h0, 1'b0);
    idle(1);

    // Read-during-write, then readback; more writes saturate the small counter.
    step(1'b1, 1'b1, 2'd1, 4'h3, 1'b0);
    step(1'b1, 1'b0, 2'd1, 4'h0, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'h7, 1'b0);
    idle(1);

    // Clear together with a read request: request dropped, memory zeroed.
    step(1'b1, 1'b0, 2'd1, 4'h0, 1'b1);
    step(1'b1, 1'b1, 2'd2, 4'h9, 1'b0);   // ignored while busy
    idle(4);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 2'(i), 4'h0, 1'b0);

    // Reset two cycles into the zero-fill.
    step(1'b1, 1'b1, 2'd2, 4'hC, 1'b0);
    do_reset();
    idle(2);
    do_reset();
    step(1'b1, 1'b1, 2'd3, 4'h6, 1'b0);   // ignored while busy
    idle(4);
    step(1'b1, 1'b0, 2'd3, 4'h0, 1'b0);

    // Clear re-asserted in the middle of a zero-fill.
    step(1'b1, 1'b1, 2'd0, 4'hE, 1'b0);
    step(1'b0, 1'b0, 2'd0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b1, 2'd1, 4'h4, 1'b1);
    idle(5);
    step(1'b1, 1'b0, 2'd0, 4'h0, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 39) == 0));
      end
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
